// File: rtl/smg_pkg.sv
// Shared digit codes, segment patterns and FSM state type for the
// multiplexed 7-segment display path.
package smg_pkg;

  localparam logic [3:0] BLANK = 4'hF;
  localparam logic [3:0] DASH  = 4'hA;

  // Active-high g..a patterns
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      DASH:    seg = SEG_DASH;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/smg_scan_display_param_if.sv
// Valid/ready input channel carrying the binary value to be displayed.
interface smg_scan_display_param_if #(
  parameter int BIN_W = 24
) ();
  logic [BIN_W-1:0] Bin_Data;
  logic             Bin_Valid;
  logic             Bin_Ready;

  modport master (output Bin_Data, output Bin_Valid, input Bin_Ready);
  modport slave  (input Bin_Data, input Bin_Valid, output Bin_Ready);
endinterface

// File: rtl/smg_bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, BIN_W cycles per value.
module smg_bin2bcd_seq #(
  parameter int BIN_W  = 24,
  parameter int DIGITS = 6
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]    sh_q, sh_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                last;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    last   = (cnt_q == CNT_W'(BIN_W - 1));
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      sh_d   = bin_in;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      sh_d  = sh_q << 1;
      bcd_d = {adj[4*DIGITS-2:0], sh_q[BIN_W-1]};
      cnt_d = cnt_q + CNT_W'(1);
      if (last) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // done flags the cycle performing the final shift; bcd_out is complete after it
  assign done    = busy_q && last;
  assign busy    = busy_q;
  assign bcd_out = bcd_q;

endmodule

// File: rtl/smg_scan_display_param.sv
// Binary-to-BCD display controller driving a multiplexed DIGITS-wide
// 7-segment display with blanking, decimal points and overflow dashes.
module smg_scan_display_param
  import smg_pkg::*;
#(
  parameter int DIGITS          = 6,
  parameter int BIN_W           = 24,
  parameter int CLK_HZ          = 50_000_000,
  parameter int SCAN_HZ         = 1000,
  parameter bit SEG_ACTIVE_LOW  = 1'b1,
  parameter bit SCAN_ACTIVE_LOW = 1'b1,
  parameter bit LZ_BLANK        = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  smg_scan_display_param_if.slave bin_if,
  input  logic [DIGITS-1:0]    Dp_Mask,
  input  logic                 Blank,
  output logic                 Overflow,
  output logic [7:0]           SMG_Data,
  output logic [DIGITS-1:0]    Scan_Sig
);

  localparam int DIV     = CLK_HZ / SCAN_HZ;
  localparam int PRESC_W = $clog2(DIV);
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [63:0]       MAXV      = pow10(DIGITS) - 64'd1;
  localparam logic [7:0]        SEG_IDLE  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SCAN_IDLE = SCAN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  state_t               state_q, state_d;
  logic                 ovf_flag_q, ovf_flag_d;
  logic                 bin_ready_q, bin_ready_d;
  logic                 overflow_q, overflow_d;
  logic [3:0]           digit_q [DIGITS];
  logic [3:0]           digit_d [DIGITS];
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [7:0]           smg_q, smg_d;
  logic [DIGITS-1:0]    scan_q, scan_d;

  logic                 start, eng_busy, eng_done;
  logic [4*DIGITS-1:0]  bcd;
  logic [63:0]          bin_ext;
  logic [3:0]           nib;
  logic                 lead;
  logic                 tick, dead;
  logic [7:0]           seg_raw;
  logic [DIGITS-1:0]    onehot;

  smg_bin2bcd_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .start   (start),
    .bin_in  (bin_if.Bin_Data),
    .busy    (eng_busy),
    .done    (eng_done),
    .bcd_out (bcd)
  );

  assign bin_ext = 64'(bin_if.Bin_Data);

  always_comb begin
    state_d    = state_q;
    ovf_flag_d = ovf_flag_q;
    start      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bin_if.Bin_Valid && bin_ready_q) begin
          if (bin_ext > MAXV) begin
            ovf_flag_d = 1'b1;
            state_d    = COMMIT;
          end else begin
            ovf_flag_d = 1'b0;
            start      = 1'b1;
            state_d    = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (eng_done) begin
          state_d = COMMIT;
        end else if (!eng_busy) begin
          state_d = IDLE;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    bin_ready_d = (state_d == IDLE);
  end

  // Walk from the top nibble down; lead stays set while every nibble so far is zero
  always_comb begin
    digit_d    = digit_q;
    overflow_d = overflow_q;
    nib        = 4'd0;
    lead       = 1'b1;
    if (state_q == COMMIT) begin
      overflow_d = ovf_flag_q;
      for (int i = DIGITS - 1; i >= 0; i--) begin
        nib  = bcd[4*i +: 4];
        lead = lead && (nib == 4'd0);
        if (ovf_flag_q) begin
          digit_d[i] = DASH;
        end else if (LZ_BLANK && lead && (i != 0)) begin
          digit_d[i] = BLANK;
        end else begin
          digit_d[i] = nib;
        end
      end
    end
  end

  // Segments follow the new index on the dead cycle; the select waits one more cycle
  always_comb begin
    tick    = (presc_q == PRESC_W'(DIV - 1));
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    dead    = (presc_d == PRESC_W'(DIV - 1)) || (presc_d == '0);
    seg_raw = {Dp_Mask[idx_d], seg_decode(digit_q[idx_d])};
    onehot  = DIGITS'(1) << idx_d;
    smg_d   = Blank ? SEG_IDLE : (SEG_ACTIVE_LOW ? ~seg_raw : seg_raw);
    scan_d  = (Blank || dead) ? SCAN_IDLE : (SCAN_ACTIVE_LOW ? ~onehot : onehot);
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      ovf_flag_q  <= 1'b0;
      bin_ready_q <= 1'b1;
      overflow_q  <= 1'b0;
      presc_q     <= '0;
      idx_q       <= '0;
      smg_q       <= SEG_IDLE;
      scan_q      <= SCAN_IDLE;
      for (int i = 0; i < DIGITS; i++) begin
        digit_q[i] <= BLANK;
      end
    end else begin
      state_q     <= state_d;
      ovf_flag_q  <= ovf_flag_d;
      bin_ready_q <= bin_ready_d;
      overflow_q  <= overflow_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      smg_q       <= smg_d;
      scan_q      <= scan_d;
      for (int i = 0; i < DIGITS; i++) begin
        digit_q[i] <= digit_d[i];
      end
    end
  end

  assign bin_if.Bin_Ready = bin_ready_q;
  assign Overflow         = overflow_q;
  assign SMG_Data         = smg_q;
  assign Scan_Sig         = scan_q;

endmodule

// File: tb/tb_smg_scan_display_param.sv
// Directed bench for smg_scan_display_param with a 4-cycle digit dwell.
module tb_smg_scan_display_param;

  localparam int DIGITS = 6;
  localparam int BIN_W  = 24;

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic [DIGITS-1:0] Dp_Mask = '0;
  logic              Blank = 1'b0;
  logic              Overflow;
  logic [7:0]        SMG_Data;
  logic [DIGITS-1:0] Scan_Sig;

  int tests_run    = 0;
  int tests_failed = 0;

  smg_scan_display_param_if #(.BIN_W(BIN_W)) bin_if ();

  smg_scan_display_param #(
    .DIGITS          (DIGITS),
    .BIN_W           (BIN_W),
    .CLK_HZ          (1000),
    .SCAN_HZ         (250),
    .SEG_ACTIVE_LOW  (1'b1),
    .SCAN_ACTIVE_LOW (1'b1),
    .LZ_BLANK        (1'b1)
  ) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .bin_if   (bin_if),
    .Dp_Mask  (Dp_Mask),
    .Blank    (Blank),
    .Overflow (Overflow),
    .SMG_Data (SMG_Data),
    .Scan_Sig (Scan_Sig)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  // Present one value for a single cycle, then count cycles until Bin_Ready returns
  task automatic send(input logic [BIN_W-1:0] v, output int lat);
    @(negedge CLK);
    bin_if.Bin_Data  = v;
    bin_if.Bin_Valid = 1'b1;
    @(negedge CLK);
    bin_if.Bin_Valid = 1'b0;
    lat = 0;
    while (!bin_if.Bin_Ready && lat < 200) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic rd(input string tag, input int i, input logic [7:0] exp);
    logic [DIGITS-1:0] sel;
    int n;
    sel = ~(DIGITS'(1) << i);
    n = 0;
    @(negedge CLK);
    while (Scan_Sig !== sel && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (Scan_Sig !== sel) chk({tag, "_sel"}, 32'(Scan_Sig), 32'(sel));
    else chk(tag, 32'(SMG_Data), 32'(exp));
  endtask

  task automatic rd_all(input string tag, input logic [7:0] exp [DIGITS]);
    for (int i = 0; i < DIGITS; i++) begin
      rd($sformatf("%s_d%0d", tag, i), i, exp[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    logic [7:0] e [DIGITS];
    logic [DIGITS-1:0] prev_scan, cur, want;
    logic [7:0] prev_smg;
    int idle_run, act_run, last_idx, k, trans;

    bin_if.Bin_Data  = '0;
    bin_if.Bin_Valid = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_ready", 32'(bin_if.Bin_Ready), 32'd1);
    chk("rst_ovf", 32'(Overflow), 32'd0);
    chk("rst_smg", 32'(SMG_Data), 32'hFF);
    chk("rst_scan", 32'(Scan_Sig), 32'h3F);
    RSTn = 1'b1;

    // 123456: full-width conversion
    send(24'd123456, lat);
    chk("t1_lat", 32'(lat), 32'd25);
    e = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    rd_all("t1", e);

    // Leading-zero blanking and zero
    send(24'd42, lat);
    chk("t2_lat", 32'(lat), 32'd25);
    e = '{8'hA4, 8'h99, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    rd_all("t2a", e);
    send(24'd0, lat);
    e = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    rd_all("t2b", e);

    // Overflow: 1-cycle path, dashes, then cleared by an in-range value
    send(24'd1_000_000, lat);
    chk("t3_lat", 32'(lat), 32'd1);
    chk("t3_ovf", 32'(Overflow), 32'd1);
    e = '{8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
    rd_all("t3a", e);
    send(24'd999_999, lat);
    chk("t3_max_lat", 32'(lat), 32'd25);
    chk("t3_max_ovf", 32'(Overflow), 32'd0);
    rd("t3_max_d5", 5, 8'h90);
    send(24'd7, lat);
    chk("t3_ovf_clr", 32'(Overflow), 32'd0);
    rd("t3b_d0", 0, 8'hF8);
    rd("t3b_d1", 1, 8'hFF);

    // Scan sequence: rotation order, dead time, active width, settled segments
    @(negedge CLK);
    prev_scan = Scan_Sig;
    prev_smg  = SMG_Data;
    idle_run = 0; act_run = 0; last_idx = -1; trans = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      cur = Scan_Sig;
      if (cur == 6'h3F) begin
        if (prev_scan != 6'h3F && last_idx >= 0) chk("t4_active_len", 32'(act_run), 32'd2);
        idle_run = (prev_scan == 6'h3F) ? idle_run + 1 : 1;
        act_run = 0;
      end else begin
        if (prev_scan == 6'h3F) begin
          trans++;
          k = -1;
          for (int j = 0; j < DIGITS; j++) if (cur == ~(DIGITS'(1) << j)) k = j;
          if (last_idx >= 0) begin
            want = ~(DIGITS'(1) << ((last_idx + 1) % DIGITS));
            chk("t4_order", 32'(cur), 32'(want));
            chk("t4_dead_len", 32'(idle_run), 32'd2);
          end
          chk("t4_settled", 32'(SMG_Data), 32'(prev_smg));
          last_idx = (k >= 0) ? k : 0;
        end
        act_run++;
      end
      prev_scan = cur;
      prev_smg  = SMG_Data;
    end
    chk("t4_transitions", 32'(trans), 32'd15);

    // Valid during SHIFT is ignored
    @(negedge CLK);
    bin_if.Bin_Data  = 24'd555;
    bin_if.Bin_Valid = 1'b1;
    @(negedge CLK);
    bin_if.Bin_Valid = 1'b0;
    repeat (3) @(negedge CLK);
    bin_if.Bin_Data  = 24'd999;
    bin_if.Bin_Valid = 1'b1;
    repeat (5) @(negedge CLK);
    bin_if.Bin_Valid = 1'b0;
    n = 0;
    while (!bin_if.Bin_Ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("t5_ready_back", 32'(bin_if.Bin_Ready), 32'd1);
    e = '{8'h92, 8'h92, 8'h92, 8'hFF, 8'hFF, 8'hFF};
    rd_all("t5a", e);

    // Reset mid-conversion aborts and blanks everything
    @(negedge CLK);
    bin_if.Bin_Data  = 24'd123;
    bin_if.Bin_Valid = 1'b1;
    @(negedge CLK);
    bin_if.Bin_Valid = 1'b0;
    repeat (5) @(negedge CLK);
    chk("t5_busy", 32'(bin_if.Bin_Ready), 32'd0);
    RSTn = 1'b0;
    @(negedge CLK);
    chk("t5_rst_ready", 32'(bin_if.Bin_Ready), 32'd1);
    chk("t5_rst_scan", 32'(Scan_Sig), 32'h3F);
    chk("t5_rst_smg", 32'(SMG_Data), 32'hFF);
    chk("t5_rst_ovf", 32'(Overflow), 32'd0);
    RSTn = 1'b1;
    repeat (30) @(negedge CLK);
    chk("t5_post_ready", 32'(bin_if.Bin_Ready), 32'd1);
    rd("t5_post_d0", 0, 8'hFF);

    // Decimal point on digit 2 only, then forced blank
    Dp_Mask = 6'b000100;
    send(24'd12345, lat);
    chk("t6_lat", 32'(lat), 32'd25);
    e = '{8'h92, 8'h99, 8'h30, 8'hA4, 8'hF9, 8'hFF};
    rd_all("t6", e);
    @(negedge CLK);
    Blank = 1'b1;
    @(negedge CLK);
    chk("t6_blank_scan", 32'(Scan_Sig), 32'h3F);
    chk("t6_blank_smg", 32'(SMG_Data), 32'hFF);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (Scan_Sig != 6'h3F) n++;
    end
    chk("t6_blank_hold", 32'(n), 32'd0);
    Blank = 1'b0;
    rd("t6_unblank_d2", 2, 8'h30);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
